carrier_demod_sin: RTL

Receive-side carrier demodulator for the sine (in-phase) branch of the 16-QAM chain. It multiplies each incoming carrier sample by the same 16-phase shift-add sine table the transmitter uses, and integrates the products over one 16-sample carrier period. Each completed symbol produces a recovered 16-bit amplitude and a 2-bit Gray-coded level decision. It sits between the ADC/sample front end and the symbol demapper.

---
 rtl/carrier_demod_sin.sv | 89 ++++++++
 1 files changed

// File: rtl/carrier_demod_sin.sv
// carrier_demod_sin: 16-phase sine-branch carrier demodulator with integrate-and-dump and 2-bit slicer.
// Define CARRIER_DEMOD_SLICER_EN to build the level slicer; otherwise sym_out is tied to 00.
module carrier_demod_sin #(
  parameter int WIDTH_SYM = 16,
  parameter int LEVEL_THR = 16384
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic                        sym_sync,
  input  logic signed [WIDTH_SYM-1:0] data_in,
  output logic signed [WIDTH_SYM-1:0] demod_out,
  output logic [1:0]                  sym_out,
  output logic                        out_valid,
  output logic [3:0]                  phase
);
  logic [3:0] phase_cnt, p;
  logic [2:0] k, amp;
  logic [15:0] du, m, c1, c2, c3, coef;
  logic neg;
  logic signed [16:0] prod_d, prod_r, q;
  logic prod_v, prod_first, prod_last;
  logic signed [19:0] acc, s;
  logic signed [15:0] sat;
  assign phase = phase_cnt;
  always_comb begin
    p = sym_sync ? 4'd0 : phase_cnt;
    k = p[2:0];
    amp = (k > 3'd4) ? 3'd0 - k : k;
    du = data_in;
    m = du[15] ? ((du == 16'h8000) ? 16'h7fff : ~du + 16'd1) : du;
    c1 = (m >> 2) + (m >> 3) + (m >> 8) + (m >> 9) + (m >> 10) + (m >> 11) + (m >> 12);
    c2 = (m >> 1) + (m >> 3) + (m >> 4) + (m >> 6) + (m >> 8);
    c3 = (m >> 1) + (m >> 2) + (m >> 3) + (m >> 5) + (m >> 6) + (m >> 9);
    coef = (amp == 3'd1) ? c1 : (amp == 3'd2) ? c2 : (amp == 3'd3) ? c3 : (amp == 3'd4) ? m : 16'd0;
    // second half-period of the sine is negative; phase 8 has a zero coefficient so p[3] suffices
    neg = du[15] ^ p[3];
    prod_d = neg ? -$signed({1'b0, coef}) : $signed({1'b0, coef});
    s = (prod_first ? 20'sd0 : acc) + $signed({{3{prod_r[16]}}, prod_r});
    q = 17'(s >>> 3);
    sat = (!q[16] && q[15]) ? 16'sh7fff : (q[16] && !q[15]) ? 16'sh8000 : q[15:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= 4'd0;
      prod_r <= '0;
      prod_v <= 1'b0;
      prod_first <= 1'b0;
      prod_last <= 1'b0;
      acc <= '0;
      demod_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      prod_v <= sample_valid;
      if (sample_valid) begin
        phase_cnt <= p + 4'd1;
        prod_r <= prod_d;
        prod_first <= (p == 4'd0);
        prod_last <= (p == 4'd15);
      end
      if (prod_v) begin
        if (prod_last) begin
          demod_out <= sat;
          out_valid <= 1'b1;
          acc <= '0;
        end else begin
          acc <= s;
        end
      end
    end
  end
`ifdef CARRIER_DEMOD_SLICER_EN
  localparam logic signed [16:0] THR_P = 17'(LEVEL_THR);
  localparam logic signed [16:0] THR_N = -THR_P;
  logic signed [16:0] sx;
  logic [1:0] lvl;
  always_comb begin
    sx = {sat[15], sat};
    lvl = (sx >= THR_P) ? 2'b10 : (sx >= 17'sd0) ? 2'b11 : (sx >= THR_N) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sym_out <= 2'b00;
    else if (prod_v && prod_last) sym_out <= lvl;
  end
`else
  assign sym_out = 2'b00;
`endif
endmodule
